fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the CPU datapath. Generates sequential instruction addresses, requests instructions from instruction memory over a request/grant/response handshake with variable latency, and buffers returned words in a small prefetch queue that the datapath drains with a valid/ready handshake. Branch and jump redirects from the datapath flush the queue and squash any in-flight request.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- QDEPTH, 2, prefetch queue entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address (word aligned)
- imem_gnt  in  1  request accepted this cycle (imem_req & imem_gnt)
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  response instruction word
- instr_valid  out  1  queue head valid
- instr  out  32  queue head instruction
- instr_pc  out  32  address of queue head instruction
- instr_ready  in  1  datapath consumes head this cycle
- redirect  in  1  discard queued/in-flight fetches, restart at redirect_pc
- redirect_pc  in  32  new fetch address

## Operation
- Registers: fetch_pc, FSM state, queue (QDEPTH × {pc, word}), count.
- States: IDLE, REQ, WAIT, DROP. imem_req = (state == REQ); imem_addr = fetch_pc.
- At most one outstanding request. Issue permitted only when count + 1 ≤ QDEPTH after any same-cycle pop.
- IDLE: → REQ when space available; else stay.
- REQ: hold imem_req/imem_addr until grant. On grant: fetch_pc += 4 (wraps modulo 2^32), → WAIT.
- WAIT: on imem_rvalid push {pc of request, imem_rdata}; → REQ if space remains after push/pop, else IDLE.
- DROP: wait for response of a squashed request; on imem_rvalid discard data, → REQ.
- Redirect (priority over all else): queue cleared, count = 0, same-cycle pop ignored, fetch_pc ← redirect_pc.
  - in IDLE, or REQ without grant → REQ (address changes next cycle; request withdrawal is legal on this interface).
  - in REQ with grant same cycle → DROP (granted request squashed).
  - in WAIT without rvalid → DROP; in WAIT with rvalid → response discarded, → REQ.
  - in DROP without rvalid → stay DROP; with rvalid → REQ.
- Queue: push and pop in the same cycle allowed; push never occurs when full (guaranteed by issue rule); pop when empty ignored.
- instr_valid = (count != 0); instr/instr_pc show head entry, stable while instr_valid & !instr_ready.

## Timing
- Reset values: state IDLE, fetch_pc RESET_PC, imem_req 0, imem_addr RESET_PC, instr_valid 0, instr 0, instr_pc 0, count 0.
- First imem_req asserted in the first cycle after reset release; reset asserted mid-request aborts immediately, outstanding response after release is not expected.
- Response in cycle N → instr_valid in N+1 (queue registered, no bypass).
- Redirect in cycle N → imem_req with redirect_pc in N+1 unless DROP, then one cycle after the squashed rvalid.
- Back-to-back single-cycle memory (gnt in REQ, rvalid next cycle): one instruction per 2 cycles.

## Structure
- Shared include: state encodings, INSTR_W = 32, PC increment constant 4, default RESET_PC.
- One sub-module: fetch_queue (synchronous FIFO, depth QDEPTH, width 64, push/pop/flush/count, full/empty).

## Test plan
- Reset release, gnt tied 1, rvalid one cycle after grant, words 0xA0..: → addrs 0x0,0x4,0x8 issued; instr_pc/instr 0x0/0xA0 valid cycle after first rvalid.
- instr_ready held 0 → exactly QDEPTH entries buffered, imem_req deasserts (IDLE); raise ready → requests resume at next PC.
- Redirect to 0x100 while in WAIT, rvalid two cycles later with 0xDEAD → 0xDEAD never appears; next request addr 0x100 after rvalid.
- Redirect to 0x200 in same cycle as grant → DROP, squashed response discarded, queue empty, next req addr 0x200.
- Redirect and rvalid same cycle, queue holding 1 entry with instr_ready=1 → queue empty next cycle, req addr = redirect_pc.
- fetch_pc = 0xFFFF_FFFC granted → next addr 0x0000_0000; async rst mid-WAIT → all outputs at reset values same cycle.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DROP
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] pc;
      logic [INSTR_W-1:0] word;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO: power-of-two depth, flush has priority over push/pop.
module fetch_queue #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 64,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // NOTE: storage is deliberately not reset; the head is forced to zero while
   // empty, so stale or uninitialised entries are never observable.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, one outstanding imem request,
// prefetch queue toward the datapath, redirect flush/squash.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          QDEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [31:0]        instr_pc,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc
);

   localparam int CNT_W = $clog2(QDEPTH) + 1;

   fetch_state_t     state;
   logic [31:0]      fetch_pc;
   fetch_entry_t     q_head;
   fetch_entry_t     q_push_data;
   logic [CNT_W-1:0] q_count;
   logic             q_full;
   logic             q_empty;
   logic             q_push;
   logic             pop_ok;
   logic             can_issue;
   logic [CNT_W:0]   fill_after_push;
   logic             room_after_push;

   assign pop_ok    = instr_ready & ~q_empty;
   assign can_issue = ~q_full | pop_ok;

   // WAIT always has a slot reserved, so this sum never exceeds QDEPTH.
   assign fill_after_push = (CNT_W+1)'(q_count) + (CNT_W+1)'(1) - (CNT_W+1)'(pop_ok);
   assign room_after_push = fill_after_push < (CNT_W+1)'(QDEPTH);

   // fetch_pc already advanced at grant, so the in-flight address is one step back.
   assign q_push      = (state == ST_WAIT) & imem_rvalid & ~redirect;
   assign q_push_data = '{pc: fetch_pc - PC_INC, word: imem_rdata};

   fetch_queue #(
      .DEPTH (QDEPTH),
      .WIDTH (2 * INSTR_W)
   ) u_queue (
      .clk       (clk),
      .rst       (rst),
      .push      (q_push),
      .push_data (q_push_data),
      .pop       (instr_ready),
      .flush     (redirect),
      .head      (q_head),
      .count     (q_count),
      .full      (q_full),
      .empty     (q_empty)
   );

   // NOTE: all state here uses non-blocking assignments so every branch sees
   // the pre-edge values of state and fetch_pc.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         fetch_pc <= RESET_PC;
      end else if (redirect) begin
         fetch_pc <= redirect_pc;
         unique case (state)
            ST_REQ:          state <= imem_gnt    ? ST_DROP : ST_REQ;
            ST_WAIT, ST_DROP: state <= imem_rvalid ? ST_REQ  : ST_DROP;
            default:         state <= ST_REQ;
         endcase
      end else begin
         unique case (state)
            ST_IDLE: if (can_issue) state <= ST_REQ;
            ST_REQ: begin
               if (imem_gnt) begin
                  fetch_pc <= fetch_pc + PC_INC;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: if (imem_rvalid) state <= room_after_push ? ST_REQ : ST_IDLE;
            ST_DROP: if (imem_rvalid) state <= ST_REQ;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign imem_req    = (state == ST_REQ);
   assign imem_addr   = fetch_pc;
   assign instr_valid = ~q_empty;
   assign instr       = q_head.word;
   assign instr_pc    = q_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed handshake/redirect/reset scenarios, then a randomized
// run against a stream-level model (sequential PCs from the last redirect, word = f(addr)).
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .QDEPTH   (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hA0 + (a >> 2);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   imem_req,    1'b0);
      check({tag, "_addr"},  imem_addr,   32'h0);
      check({tag, "_valid"}, instr_valid, 1'b0);
      check({tag, "_instr"}, instr,       32'h0);
      check({tag, "_pc"},    instr_pc,    32'h0);
   endtask

   // Drain the queue with no grants until a request shows up (bounded).
   task automatic wait_req();
      instr_ready = 1'b1;
      for (int i = 0; i < 50 && !imem_req; i++) tick();
      instr_ready = 1'b0;
      check("wait_req", imem_req, 1'b1);
   endtask

   // Randomized-phase memory model state
   bit          outst;
   logic [31:0] outst_addr;
   int          lat_cnt;
   logic [31:0] exp_pc;
   int          consumed;

   initial begin
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset");

      // Single-cycle memory, ready held low: fill, go idle, resume.
      rst = 1'b0;
      tick();
      check("first_req", imem_req, 1'b1);
      check("first_addr", imem_addr, 32'h0);
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      check("wait_no_req", imem_req, 1'b0);
      imem_rvalid = 1'b1; imem_rdata = mem_word(32'h0); tick(); imem_rvalid = 1'b0;
      check("first_valid", instr_valid, 1'b1);
      check("first_instr", instr, 32'hA0);
      check("first_pc", instr_pc, 32'h0);
      check("second_addr", imem_addr, 32'h4);
      check("second_req", imem_req, 1'b1);
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = mem_word(32'h4); tick(); imem_rvalid = 1'b0;
      check("full_idle_req", imem_req, 1'b0);
      repeat (3) tick();
      check("full_hold_req", imem_req, 1'b0);
      check("full_hold_instr", instr, 32'hA0);
      instr_ready = 1'b1; tick(); instr_ready = 1'b0;
      check("resume_req", imem_req, 1'b1);
      check("resume_addr", imem_addr, 32'h8);
      check("pop_pc", instr_pc, 32'h4);
      check("pop_instr", instr, 32'hA1);
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = mem_word(32'h8); tick(); imem_rvalid = 1'b0;
      check("refill_idle", imem_req, 1'b0);

      // Redirect while waiting for a response; late 0xDEAD must be discarded.
      wait_req();
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h100; tick(); redirect = 1'b0;
      check("drop_no_req", imem_req, 1'b0);
      check("drop_flushed", instr_valid, 1'b0);
      tick();
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD; tick(); imem_rvalid = 1'b0;
      check("redir_req", imem_req, 1'b1);
      check("redir_addr", imem_addr, 32'h100);
      check("dead_absent", instr_valid, 1'b0);
      tick();
      check("dead_absent2", instr_valid, 1'b0);

      // Redirect in the same cycle as the grant.
      imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; tick();
      imem_gnt = 1'b0; redirect = 1'b0;
      check("gnt_redir_drop", imem_req, 1'b0);
      tick();
      check("gnt_redir_hold", imem_req, 1'b0);
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0; tick(); imem_rvalid = 1'b0;
      check("gnt_redir_req", imem_req, 1'b1);
      check("gnt_redir_addr", imem_addr, 32'h200);
      check("gnt_redir_empty", instr_valid, 1'b0);

      // Redirect coinciding with rvalid and a pop of the single queued entry.
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h55; tick(); imem_rvalid = 1'b0;
      check("one_entry_pc", instr_pc, 32'h200);
      check("one_entry_instr", instr, 32'h55);
      check("one_entry_addr", imem_addr, 32'h204);
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h66; instr_ready = 1'b1;
      redirect = 1'b1; redirect_pc = 32'h300; tick();
      clear_inputs();
      check("rv_redir_empty", instr_valid, 1'b0);
      check("rv_redir_req", imem_req, 1'b1);
      check("rv_redir_addr", imem_addr, 32'h300);

      // PC wrap at the top of the address space.
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; tick(); redirect = 1'b0;
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'h11; tick(); imem_rvalid = 1'b0;
      check("wrap_next_addr", imem_addr, 32'h0);
      check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
      check("wrap_instr", instr, 32'h11);

      // Asynchronous reset mid-WAIT with a queued entry.
      imem_gnt = 1'b1; tick(); imem_gnt = 1'b0;
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      @(negedge clk);
      rst = 1'b0;

      // Randomized traffic against the stream model.
      outst    = 1'b0;
      exp_pc   = 32'h0;
      consumed = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         clear_inputs();
         if (outst) begin
            if (lat_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(outst_addr);
               outst       = 1'b0;
            end else begin
               lat_cnt--;
            end
         end
         if (imem_req) begin
            check("one_outstanding", {31'b0, outst | imem_rvalid}, 32'h0);
            check("addr_aligned", {30'b0, imem_addr[1:0]}, 32'h0);
            if ($urandom_range(99) < 60) begin
               imem_gnt   = 1'b1;
               outst      = 1'b1;
               outst_addr = imem_addr;
               lat_cnt    = $urandom_range(3);
            end
         end
         instr_ready = ($urandom_range(99) < 75);
         if ($urandom_range(99) < 3) begin
            redirect    = 1'b1;
            redirect_pc = $urandom() & 32'hFFFF_FFFC;
            exp_pc      = redirect_pc;
         end else if (instr_valid && instr_ready) begin
            check("rand_pc", instr_pc, exp_pc);
            check("rand_instr", instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         tick();
      end
      clear_inputs();
      check("rand_progress", {31'b0, consumed >= 300}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
